// File: rtl/unary_reduce_pkg.sv
// Shared types and elaboration helpers for the pipelined unary reduction tree.
// Each tree level narrows the operand by 4x; levels are packed back-to-back in one flat bus.
package unary_reduce_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  function automatic logic identity(input op_e op);
    return (op == OP_AND);
  endfunction

  function automatic logic reduce4(input op_e op, input logic [3:0] v);
    logic r;
    case (op)
      OP_AND:  r = &v;
      OP_OR:   r = |v;
      OP_XOR:  r = ^v;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Width of the partial vector after k tree levels.
  function automatic int level_width(input int n, input int k);
    int w;
    w = n;
    for (int i = 0; i < k; i++) w = (w + 3) / 4;
    return w;
  endfunction

  function automatic int num_levels(input int n);
    int lv;
    lv = 0;
    for (int w = n; w > 1; w = (w + 3) / 4) lv++;
    return lv;
  endfunction

  function automatic int level_offset(input int n, input int k);
    int off;
    off = 0;
    for (int i = 0; i < k; i++) off += level_width(n, i);
    return off;
  endfunction

endpackage

// File: rtl/unary_reduce_stage.sv
// One tree level: pads the incoming vector to a multiple of 4 with the op identity,
// reduces each group of 4, and holds the result in a bubble-collapsing register slice.
module unary_reduce_stage
  import unary_reduce_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int TAG_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_W-1:0]           in_vec,
  input  op_e                       in_op,
  input  logic                      in_inv,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [(IN_W+3)/4-1:0]     out_vec,
  output op_e                       out_op,
  output logic                      out_inv,
  output logic [TAG_W-1:0]          out_tag
);

  localparam int OUT_W = (IN_W + 3) / 4;

  logic [4*OUT_W-1:0] w_padded;
  logic [OUT_W-1:0]   w_reduced;
  logic               w_load;

  logic               r_valid;
  logic [OUT_W-1:0]   r_vec;
  op_e                r_op;
  logic               r_inv;
  logic [TAG_W-1:0]   r_tag;

  always_comb begin
    w_padded            = {(4*OUT_W){identity(in_op)}};
    w_padded[IN_W-1:0]  = in_vec;
    w_reduced           = '0;
    for (int g = 0; g < OUT_W; g++) begin
      w_reduced[g] = reduce4(in_op, w_padded[4*g +: 4]);
    end
  end

  // Load when empty or when the current contents leave this cycle; independent of in_valid.
  assign in_ready = ~r_valid | out_ready;
  assign w_load   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_vec   <= '0;
      r_op    <= OP_AND;
      r_inv   <= 1'b0;
      r_tag   <= '0;
    end else begin
      if (in_ready) r_valid <= in_valid;
      if (w_load) begin
        r_vec <= w_reduced;
        r_op  <= in_op;
        r_inv <= in_inv;
        r_tag <= in_tag;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_vec   = r_vec;
  assign out_op    = r_op;
  assign out_inv   = r_inv;
  assign out_tag   = r_tag;

endmodule

// File: rtl/pipelined_unary_reduce.sv
// Registered, back-pressured N-bit AND/OR/XOR reduction built as a radix-4 tree,
// one register level per tree level; inversion and reserved-op forcing happen at the output.
module pipelined_unary_reduce
  import unary_reduce_pkg::*;
#(
  parameter int N     = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [1:0]       in_op,
  input  logic             in_inv,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_c,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LAT      = num_levels(N);
  localparam int TOTAL_W  = level_offset(N, LAT + 1);
  localparam int LAST_OFF = level_offset(N, LAT);

  // Level k's partial vector lives at level_offset(N,k) in this flat bus; level 0 is the operand.
  logic [TOTAL_W-1:0] w_vec;
  logic [LAT:0]       w_valid;
  logic [LAT:0]       w_ready;
  logic [LAT:0]       w_inv;
  op_e                w_op  [LAT+1];
  logic [TAG_W-1:0]   w_tag [LAT+1];

  assign w_vec[N-1:0] = in_a;
  assign w_valid[0]   = in_valid;
  assign in_ready     = w_ready[0];
  assign w_op[0]      = op_e'(in_op);
  assign w_inv[0]     = in_inv;
  assign w_tag[0]     = in_tag;

  for (genvar k = 0; k < LAT; k++) begin : g_level
    localparam int IW   = level_width(N, k);
    localparam int OW   = level_width(N, k + 1);
    localparam int IOFF = level_offset(N, k);
    localparam int OOFF = level_offset(N, k + 1);

    unary_reduce_stage #(
      .IN_W  (IW),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (w_valid[k]),
      .in_ready  (w_ready[k]),
      .in_vec    (w_vec[IOFF +: IW]),
      .in_op     (w_op[k]),
      .in_inv    (w_inv[k]),
      .in_tag    (w_tag[k]),
      .out_valid (w_valid[k+1]),
      .out_ready (w_ready[k+1]),
      .out_vec   (w_vec[OOFF +: OW]),
      .out_op    (w_op[k+1]),
      .out_inv   (w_inv[k+1]),
      .out_tag   (w_tag[k+1])
    );
  end

  assign w_ready[LAT] = out_ready;
  assign out_valid    = w_valid[LAT];
  assign out_err      = (w_op[LAT] == OP_RSVD);
  assign out_c        = out_err ? 1'b0 : (w_inv[LAT] ^ w_vec[LAST_OFF]);
  assign out_tag      = w_tag[LAT];

endmodule

// File: tb/tb_pipelined_unary_reduce.sv
// Directed, table-driven bench for pipelined_unary_reduce (N=32 and N=5 instances).
// A negedge monitor scoreboards every consumed result of the N=32 unit in FIFO order.
module tb_pipelined_unary_reduce;

  localparam int N     = 32;
  localparam int TAG_W = 4;
  localparam int LAT   = 3;
  localparam int LAT5  = 2;

  typedef struct {
    logic [31:0] a;
    logic [1:0]  op;
    logic        inv;
    logic [3:0]  tag;
    logic        c;
    logic        err;
    int          cyc;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;

  logic             in_valid, in_ready, in_inv, out_valid, out_ready, out_c, out_err;
  logic [N-1:0]     in_a;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag, out_tag;

  logic             v5, r5, inv5, ov5, ordy5, c5, err5;
  logic [4:0]       a5;
  logic [1:0]       op5;
  logic [TAG_W-1:0] tag5, otag5;

  int   nVec = 0;
  int   nErr = 0;
  int   cyc = 0;
  bit   latChk = 1'b0;
  vec_t curExp;
  vec_t sbq[$];
  vec_t tbl[8];
  vec_t bp[5];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pipelined_unary_reduce #(.N(N), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_op(in_op),
    .in_inv(in_inv), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
    .out_err(out_err), .out_tag(out_tag)
  );

  pipelined_unary_reduce #(.N(5), .TAG_W(TAG_W)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v5), .in_ready(r5), .in_a(a5), .in_op(op5),
    .in_inv(inv5), .in_tag(tag5),
    .out_valid(ov5), .out_ready(ordy5), .out_c(c5),
    .out_err(err5), .out_tag(otag5)
  );

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: pop and compare on every consumed result, push on every accepted word.
  always @(negedge clk) begin
    vec_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          checkOutput($sformatf("c_tag%0d", e.tag), 32'(out_c), 32'(e.c));
          checkOutput($sformatf("err_tag%0d", e.tag), 32'(out_err), 32'(e.err));
          checkOutput($sformatf("tag_tag%0d", e.tag), 32'(out_tag), 32'(e.tag));
          if (latChk) checkOutput($sformatf("lat_tag%0d", e.tag), cyc - e.cyc, LAT);
        end
      end
      if (in_valid && in_ready) begin
        e     = curExp;
        e.cyc = cyc;
        sbq.push_back(e);
      end
    end
  end

  // Entered and left just after a rising edge; returns once the word has been taken.
  task automatic applyStimulus(input vec_t v);
    int waitCnt;
    waitCnt  = 0;
    curExp   = v;
    in_valid = 1'b1;
    in_a     = v.a;
    in_op    = v.op;
    in_inv   = v.inv;
    in_tag   = v.tag;
    @(negedge clk);
    while (!in_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic goIdle();
    in_valid = 1'b0;
    in_a     = 'x;
    in_op    = 'x;
    in_inv   = 'x;
    in_tag   = 'x;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_empty", sbq.size(), 0);
  endtask

  task automatic run5(input string nm, input logic [4:0] a, input logic [1:0] op, input logic expC);
    int cnt;
    cnt  = 1;
    v5   = 1'b1;
    a5   = a;
    op5  = op;
    inv5 = 1'b0;
    tag5 = 4'h9;
    @(negedge clk);
    checkOutput({nm, "_ready"}, 32'(r5), 32'd1);
    @(posedge clk);
    #1;
    v5  = 1'b0;
    a5  = 'x;
    op5 = 'x;
    @(negedge clk);
    while (!ov5 && cnt < 10) begin
      @(posedge clk);
      #1;
      cnt++;
      @(negedge clk);
    end
    checkOutput({nm, "_lat"}, cnt, LAT5);
    checkOutput({nm, "_c"}, 32'(c5), 32'(expC));
    checkOutput({nm, "_err"}, 32'(err5), 32'd0);
    checkOutput({nm, "_tag"}, 32'(otag5), 32'h9);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int stale;

    tbl[0] = '{32'h0000_0100, 2'd1, 1'b0, 4'd5, 1'b1, 1'b0, 0};
    tbl[1] = '{32'h0000_0000, 2'd1, 1'b0, 4'd6, 1'b0, 1'b0, 0};
    tbl[2] = '{32'hFFFF_FFFF, 2'd0, 1'b0, 4'd0, 1'b1, 1'b0, 0};
    tbl[3] = '{32'hFFFF_FFFE, 2'd0, 1'b0, 4'd1, 1'b0, 1'b0, 0};
    tbl[4] = '{32'h0000_0007, 2'd2, 1'b0, 4'd2, 1'b1, 1'b0, 0};
    tbl[5] = '{32'h0000_0003, 2'd2, 1'b1, 4'd3, 1'b1, 1'b0, 0};
    tbl[6] = '{32'h0000_0000, 2'd1, 1'b1, 4'd4, 1'b1, 1'b0, 0};
    tbl[7] = '{32'hFFFF_FFFF, 2'd3, 1'b0, 4'd5, 1'b0, 1'b1, 0};

    bp[0] = '{32'hFFFF_FFFF, 2'd0, 1'b0, 4'd8,  1'b1, 1'b0, 0};
    bp[1] = '{32'h0000_0000, 2'd1, 1'b0, 4'd9,  1'b0, 1'b0, 0};
    bp[2] = '{32'h0000_0001, 2'd2, 1'b0, 4'd10, 1'b1, 1'b0, 0};
    bp[3] = '{32'h0000_0000, 2'd0, 1'b1, 4'd11, 1'b1, 1'b0, 0};
    bp[4] = '{32'h0000_000F, 2'd2, 1'b0, 4'd12, 1'b0, 1'b0, 0};

    goIdle();
    out_ready = 1'b1;
    v5 = 1'b0; a5 = '0; op5 = '0; inv5 = 1'b0; tag5 = '0; ordy5 = 1'b1;

    $display("[TB] post-reset idle");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_c", 32'(out_c), 32'd0);
    checkOutput("rst_out_err", 32'(out_err), 32'd0);
    checkOutput("rst_out_tag", 32'(out_tag), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst5_out_valid", 32'(ov5), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] single words, no stall");
    latChk = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(tbl[i]);
      goIdle();
      drain();
    end

    $display("[TB] back-to-back stream of all ops");
    for (int i = 2; i < 8; i++) applyStimulus(tbl[i]);
    goIdle();
    drain();

    $display("[TB] back-pressure");
    latChk    = 1'b0;
    out_ready = 1'b0;
    acc       = 0;
    for (int i = 0; i < 5; i++) begin
      curExp   = bp[acc];
      in_valid = 1'b1;
      in_a     = bp[acc].a;
      in_op    = bp[acc].op;
      in_inv   = bp[acc].inv;
      in_tag   = bp[acc].tag;
      @(negedge clk);
      if (i >= 3) begin
        checkOutput($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
        checkOutput($sformatf("bp_hold_valid_%0d", i), 32'(out_valid), 32'd1);
        checkOutput($sformatf("bp_hold_c_%0d", i), 32'(out_c), 32'(bp[0].c));
        checkOutput($sformatf("bp_hold_tag_%0d", i), 32'(out_tag), 32'(bp[0].tag));
      end
      if (in_ready) acc++;
      @(posedge clk);
      #1;
    end
    checkOutput("bp_accepts", acc, 3);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_resume_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(bp[4]);
    goIdle();
    drain();

    $display("[TB] padding with N=5");
    run5("pad_and", 5'b11111, 2'd0, 1'b1);
    run5("pad_or",  5'b10000, 2'd1, 1'b1);
    run5("pad_xor", 5'b10001, 2'd2, 1'b0);

    $display("[TB] reset mid-flight");
    out_ready = 1'b0;
    applyStimulus('{32'hFFFF_FFFF, 2'd0, 1'b0, 4'd13, 1'b1, 1'b0, 0});
    applyStimulus('{32'h0000_0001, 2'd1, 1'b0, 4'd14, 1'b1, 1'b0, 0});
    goIdle();
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    sbq.delete();
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_c", 32'(out_c), 32'd0);
    checkOutput("mid_rst_tag", 32'(out_tag), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    stale     = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checkOutput("mid_no_stale", stale, 0);
    checkOutput("mid_in_ready", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
